// File: rtl/rr_arbiter_mux_8x1.sv
// Round-robin arbiter owning the select line of an 8:1 single-bit mux.
// One requester is granted at a time; a grant ends when its request drops or
// after MAX_HOLD cycles, followed by exactly one idle cycle before the next grant.
module rr_arbiter_mux_8x1 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] a,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       y
);

  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          r_state;
  logic [2:0]      r_sel;
  logic [7:0]      r_gnt;
  logic            r_busy;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_ptr;

  logic [2:0]      w_win;
  logic            w_found;
  logic            w_release;

  // Circular first-set search over req starting at the priority pointer.
  always_comb begin
    logic [2:0] idx;
    w_win   = r_ptr;
    w_found = 1'b0;
    idx     = r_ptr;
    for (int i = 0; i < 8; i++) begin
      idx = r_ptr + 3'(i);
      if (!w_found && req[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  // Grant ends on request drop or when the hold budget is spent.
  always_comb begin
    w_release = !req[r_sel] || (r_cnt == CntW'(MAX_HOLD - 1));
  end

  // Arbiter FSM with registered select, grant and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_sel   <= 3'd0;
      r_gnt   <= 8'd0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= 3'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state <= StBusy;
            r_sel   <= w_win;
            r_gnt   <= 8'd1 << w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        StBusy: begin
          if (w_release) begin
            r_state <= StIdle;
            r_gnt   <= 8'd0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            // 3-bit add wraps 7 back to 0.
            r_ptr   <= r_sel + 3'd1;
          end else begin
            r_cnt   <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Data path: granted requester's bit, forced low when idle.
  always_comb begin
    y = r_busy ? a[r_sel] : 1'b0;
  end

  assign sel  = r_sel;
  assign gnt  = r_gnt;
  assign busy = r_busy;

endmodule

// File: tb/tb_rr_arbiter_mux_8x1.sv
// Self-checking bench for rr_arbiter_mux_8x1: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_rr_arbiter_mux_8x1;

  localparam int unsigned MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] a;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       y;

  rr_arbiter_mux_8x1 #(.MAX_HOLD(MaxHold)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a    (a),
    .sel  (sel),
    .gnt  (gnt),
    .busy (busy),
    .y    (y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] a;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t vecs [18];

  // Behavioural model: who owns the mux, for how many cycles, and where the
  // next search starts.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_held;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] esel, input logic [7:0] egnt,
                            input logic ebusy, input logic ey);
    chk({tag, ".sel"},  {5'd0, sel},  {5'd0, esel});
    chk({tag, ".gnt"},  gnt,          egnt);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, ebusy});
    chk({tag, ".y"},    {7'd0, y},    {7'd0, ey});
  endtask

  // Apply inputs, let one rising edge pass, settle before sampling.
  task automatic cyc(input logic r, input logic [7:0] q, input logic [7:0] d);
    rst = r;
    req = q;
    a   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, input logic [7:0] q);
    if (r) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (q[(m_ptr + k) % 8]) begin
          m_busy = 1;
          m_sel  = (m_ptr + k) % 8;
          m_held = 1;
          break;
        end
      end
    end else if (!q[m_sel] || m_held == MaxHold) begin
      m_busy = 0;
      m_ptr  = (m_sel + 1) % 8;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] egnt;
    egnt = m_busy ? (8'd1 << m_sel) : 8'd0;
    check_outs(tag, 3'(m_sel), egnt, m_busy, m_busy ? a[m_sel] : 1'b0);
  endtask

  initial begin
    logic [7:0] q;
    rst = 1'b1;
    req = 8'h00;
    a   = 8'h00;

    //            rst   req    a      sel   gnt    busy  y
    vecs[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h04, 8'h04, 3'd2, 8'h04, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 8'h04, 8'h00, 3'd2, 8'h04, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 3'd2, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h08, 8'h08, 3'd3, 8'h08, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h08, 8'h08, 3'd3, 8'h08, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 8'h08, 3'd3, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h11, 8'h00, 3'd4, 8'h10, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 3'd4, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h05, 8'h01, 3'd0, 8'h01, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 8'h01, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h05, 8'h01, 3'd2, 8'h04, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 3'd2, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h40, 8'h40, 3'd6, 8'h40, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'h40, 8'h40, 3'd6, 8'h40, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 8'h40, 8'h40, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h81, 8'h00, 3'd0, 8'h01, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].rst, vecs[i].req, vecs[i].a);
      check_outs($sformatf("vec%0d", i), vecs[i].sel, vecs[i].gnt, vecs[i].busy, vecs[i].y);
    end

    // Idle with no requests: outputs stay quiet even with all data high.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 8'hFF);
      check_outs($sformatf("noreq%0d", i), 3'd0, 8'h00, 1'b0, 1'b0);
    end

    // y follows a[sel] combinationally during a grant.
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h04, 8'h04);
    check_outs("comb_y.grant", 3'd2, 8'h04, 1'b1, 1'b1);
    a = 8'h00;
    #1;
    chk("comb_y.fall", {7'd0, y}, 8'h00);
    a = 8'hFB;
    #1;
    chk("comb_y.other_bits", {7'd0, y}, 8'h00);
    a = 8'h04;
    #1;
    chk("comb_y.rise", {7'd0, y}, 8'h01);

    // Full load: grants rotate 0..7,0 with MaxHold busy cycles then one idle.
    cyc(1'b1, 8'h00, 8'h00);
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < int'(MaxHold); c++) begin
        cyc(1'b0, 8'hFF, 8'hFF);
        check_outs($sformatf("full.g%0d.c%0d", g, c), 3'(g % 8), 8'd1 << (g % 8), 1'b1, 1'b1);
      end
      cyc(1'b0, 8'hFF, 8'hFF);
      check_outs($sformatf("full.g%0d.idle", g), 3'(g % 8), 8'h00, 1'b0, 1'b0);
    end

    // Randomized traffic against the model.
    cyc(1'b1, 8'h00, 8'h00);
    model_step(1'b1, 8'h00);
    check_model("rnd.reset");
    q = 8'h00;
    for (int n = 0; n < 800; n++) begin
      logic r;
      r = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 5))
        0:       q = 8'($urandom);
        1:       q = q ^ (8'd1 << $urandom_range(0, 7));
        2:       q = 8'h00;
        default: q = q;
      endcase
      cyc(r, q, 8'($urandom));
      model_step(r, q);
      check_model($sformatf("rnd%0d", n));
      a = 8'($urandom);
      #1;
      chk($sformatf("rnd%0d.ymid", n), {7'd0, y},
          {7'd0, (m_busy ? a[m_sel] : 1'b0)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
